// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential radix-2 divider.
// FSM state encoding and default operand width.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration.
// Shifts in a dividend bit and trial-subtracts the divisor.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   // Keep the difference when non-negative, else restore the shifted value.
   always_comb begin
      sh    = {rem_i, bit_i};
      diff  = sh - {1'b0, dvs_i};
      q_o   = ~diff[WIDTH];
      rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider.
// One quotient bit per clock, sign fix-up in a final cycle.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             dz_q;
   logic             ovf_q;

   logic [WIDTH-1:0] rem_d;
   logic             qbit_d;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             b_zero;
   logic             is_ovf;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign in_ready = (state_q == IDLE) && !rst;

   // Operand magnitudes and special-case detection at accept time.
   always_comb begin
      a_neg  = is_signed & dividend[WIDTH-1];
      b_neg  = is_signed & divisor[WIDTH-1];
      a_mag  = a_neg ? -dividend : dividend;
      b_mag  = b_neg ? -divisor : divisor;
      b_zero = (divisor == '0);
      is_ovf = is_signed && (dividend == MIN) && (divisor == '1);
   end

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_i(rem_q),
      .bit_i(quo_q[WIDTH-1]),
      .dvs_i(dvs_q),
      .rem_o(rem_d),
      .q_o  (qbit_d)
   );

   // Final results: divide-by-zero keeps the raw dividend held in quo_q.
   always_comb begin
      q_fix = qneg_q ? -quo_q : quo_q;
      r_fix = rneg_q ? -rem_q : rem_q;
      if (dz_q) begin
         q_fix = '1;
         r_fix = quo_q;
      end
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= b_zero ? dividend : a_mag;
                  dvs_q   <= b_mag;
                  qneg_q  <= a_neg ^ b_neg;
                  rneg_q  <= a_neg;
                  dz_q    <= b_zero;
                  ovf_q   <= is_ovf;
                  state_q <= b_zero ? FIX : CALC;
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[WIDTH-2:0], qbit_d};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= FIX;
               end
            end
            FIX: begin
               quotient    <= q_fix;
               remainder   <= r_fix;
               div_by_zero <= dz_q;
               overflow    <= ovf_q;
               done        <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider.
// Covers 32-bit directed cases and an 8-bit reference sweep.
module tb_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v32, s32, rdy32, d32, z32, o32;
   logic [31:0] a32, b32, q32, r32;
   logic        v8, s8, rdy8, d8, z8, o8;
   logic [7:0]  a8, b8, q8, r8;

   int checks = 0;
   int failures = 0;

   seq_divider #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst),
      .in_valid(v32), .in_ready(rdy32),
      .is_signed(s32), .dividend(a32), .divisor(b32),
      .quotient(q32), .remainder(r32), .done(d32),
      .div_by_zero(z32), .overflow(o32)
   );

   seq_divider #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst),
      .in_valid(v8), .in_ready(rdy8),
      .is_signed(s8), .dividend(a8), .divisor(b8),
      .quotient(q8), .remainder(r8), .done(d8),
      .div_by_zero(z8), .overflow(o8)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic op32(input string tag, input logic sg,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic ez, input logic eo, input int elat);
      int n;
      @(negedge clk);
      chk({tag, ".rdy"}, rdy32, 1);
      v32 = 1; s32 = sg; a32 = a; b32 = b;
      @(posedge clk); #1;
      v32 = 0; s32 = ~sg; a32 = ~a; b32 = ~b;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 5 && elat > 5) chk({tag, ".busy"}, rdy32, 0);
      end while (!d32 && n < 100);
      chk({tag, ".lat"}, n, elat);
      chk({tag, ".q"}, q32, eq);
      chk({tag, ".r"}, r32, er);
      chk({tag, ".dz"}, z32, ez);
      chk({tag, ".ov"}, o32, eo);
      @(posedge clk); #1;
      chk({tag, ".pulse"}, d32, 0);
      chk({tag, ".hold"}, q32, eq);
   endtask

   task automatic op8(input int idx, input logic sg,
                      input logic [7:0] a, input logic [7:0] b);
      int n, sa, sb, elat;
      logic [7:0] eq, er;
      logic ez, eo;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ez = (b == 8'd0);
      eo = 0;
      elat = ez ? 1 : 9;
      if (ez) begin
         eq = 8'hFF; er = a;
      end else if (sg && a == 8'h80 && b == 8'hFF) begin
         eq = 8'h80; er = 8'h00; eo = 1;
      end else if (sg) begin
         eq = 8'(sa / sb); er = 8'(sa % sb);
      end else begin
         eq = a / b; er = a % b;
      end
      @(negedge clk);
      v8 = 1; s8 = sg; a8 = a; b8 = b;
      @(posedge clk); #1;
      v8 = 0; a8 = ~a; b8 = ~b;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!d8 && n < 50);
      chk($sformatf("w8[%0d].lat", idx), n, elat);
      chk($sformatf("w8[%0d].q a=%h b=%h s=%0d", idx, a, b, sg),
          {24'd0, q8}, {24'd0, eq});
      chk($sformatf("w8[%0d].r", idx), {24'd0, r8}, {24'd0, er});
      chk($sformatf("w8[%0d].flags", idx), {30'd0, z8, o8},
          {30'd0, ez, eo});
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1; v32 = 0; s32 = 0; a32 = 0; b32 = 0;
      v8 = 0; s8 = 0; a8 = 0; b8 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.q", q32, 0);
      chk("rst.r", r32, 0);
      chk("rst.flags", {29'd0, d32, z32, o32}, 0);
      chk("rst.rdy", rdy32, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst.rdy_after", rdy32, 1);

      op32("u81_9", 0, 81, 9, 9, 0, 0, 0, 33);
      op32("uFF_16", 0, 32'hFFFFFFFF, 16, 32'h0FFFFFFF, 15, 0, 0, 33);
      op32("sm1_16", 1, 32'hFFFFFFFF, 16, 0, 32'hFFFFFFFF, 0, 0, 33);
      op32("sm7_2", 1, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF,
           0, 0, 33);
      op32("s7_m2", 1, 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0, 0, 33);
      op32("sm100_m7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 14,
           32'hFFFFFFFE, 0, 0, 33);
      op32("u1234_0", 0, 1234, 0, 32'hFFFFFFFF, 1234, 1, 0, 1);
      op32("sm5_0", 1, 32'hFFFFFFFB, 0, 32'hFFFFFFFF, 32'hFFFFFFFB,
           1, 0, 1);
      op32("smin_m1", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,
           0, 1, 33);
      op32("umin_ff", 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000,
           0, 0, 33);

      @(negedge clk);
      v32 = 1; s32 = 0; a32 = 100; b32 = 7;
      @(posedge clk); #1;
      a32 = 50; b32 = 5;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 10) chk("b2b.busy", rdy32, 0);
      end while (!d32 && n < 100);
      chk("b2b.lat1", n, 33);
      chk("b2b.q1", q32, 14);
      chk("b2b.r1", r32, 2);
      chk("b2b.rdy_done", rdy32, 1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) v32 = 0;
      end while (!d32 && n < 100);
      chk("b2b.gap", n, 34);
      chk("b2b.q2", q32, 10);
      chk("b2b.r2", r32, 0);

      @(negedge clk);
      v32 = 1; s32 = 0; a32 = 81; b32 = 9;
      @(posedge clk); #1;
      v32 = 0;
      seen = 0;
      repeat (9) begin
         @(posedge clk); #1;
         seen |= d32;
      end
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
      chk("abort.q", q32, 0);
      chk("abort.r", r32, 0);
      chk("abort.flags", {29'd0, d32, z32, o32}, 0);
      chk("abort.rdy_rst", rdy32, 0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("abort.rdy", rdy32, 1);
      repeat (40) begin
         @(posedge clk); #1;
         seen |= d32;
      end
      chk("abort.nodone", seen, 0);
      op32("post_81_9", 0, 81, 9, 9, 0, 0, 0, 33);

      op8(100, 1, 8'h80, 8'hFF);
      op8(101, 1, 8'h80, 8'h01);
      op8(102, 0, 8'hFF, 8'h00);
      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(0, 255));
         op8(i, i[0], ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider computing quotient and remainder of two WIDTH-bit operands, signed or unsigned per operation. Radix-2 restoring iteration, one quotient bit per clock, with a valid/ready input handshake and a one-cycle done pulse. Successor to the fixed 32-bit divider; it sits behind the execution-stage issue logic as a shared long-latency unit.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands present
- in_ready  output  1  divider can accept (high only in IDLE and rst low)
- is_signed  input  1  1 = two's-complement operation, 0 = unsigned
- dividend  input  WIDTH  numerator
- divisor  input  WIDTH  denominator
- quotient  output  WIDTH  result quotient, held until next done
- remainder  output  WIDTH  result remainder, held until next done
- done  output  1  one-cycle pulse, results valid
- div_by_zero  output  1  last result had divisor == 0, held with results
- overflow  output  1  last result was signed MIN / -1, held with results

## Operation
- Accept: posedge with in_valid && in_ready. Latches is_signed, operand magnitudes and result signs. Inputs ignored afterwards until the next accept.
- States: IDLE → CALC (divisor ≠ 0) or IDLE → FIX (divisor == 0); CALC → FIX after WIDTH iterations; FIX → IDLE.
- CALC: a log2(WIDTH)+1-bit counter runs 0..WIDTH-1. Each edge shifts {rem, quo} left by one and subtracts the divisor magnitude from the WIDTH+1-bit partial remainder. A non-negative result is kept with quotient bit 1; otherwise the partial remainder is restored and the bit is 0.
- FIX: applies signs, registers quotient/remainder/flags, pulses done.
- Signed: quotient truncates toward zero; remainder carries the dividend's sign, or is 0. Example: -7/2 → q=-3, r=-1.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero=1. Applies in both modes.
- Signed MIN / -1: quotient = MIN (0x80000000 at WIDTH=32), remainder = 0, overflow=1. No trap.
- Unsigned operations never set overflow.

## Timing
- Reset (posedge with rst high): state IDLE, counter 0, quotient 0, remainder 0, done 0, div_by_zero 0, overflow 0. in_ready is 0 while rst is high.
- Normal latency: done is high in the cycle after edge A+WIDTH+1, where A is the accept edge (WIDTH+2 edges).
- Divide-by-zero latency: done after edge A+1.
- in_ready = (state == IDLE) && !rst. It is high during the done cycle, so a back-to-back accept on that edge is legal. Throughput is one op per WIDTH+2 cycles.
- done is never held for more than one cycle. There is no output backpressure.
- Reset mid-operation: the operation aborts, done never fires for it, and outputs return to reset values.

## Structure
- Package seq_divider_pkg holds the state enum (IDLE, CALC, FIX) and a default-width localparam.
- Sub-module div_step, purely combinational: takes the partial remainder, next dividend bit and divisor magnitude; returns the new partial remainder and quotient bit. The top level holds the FSM, counter, sign handling and output registers.

## Test plan
- Unsigned 81 / 9, WIDTH=32 → q=9, r=0, flags 0; done exactly 34 cycles after the accept edge.
- Unsigned 0xFFFFFFFF / 0x10 → q=0x0FFFFFFF, r=0xF. The same operands with is_signed=1 (-1/16) → q=0, r=0xFFFFFFFF.
- Signed -7/2 → q=-3, r=-1. Signed 7/-2 → q=-3, r=1.
- 1234 / 0 → q=0xFFFFFFFF, r=1234, div_by_zero=1, done 2 cycles after accept. Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, overflow=1.
- Back-to-back: in_valid held high with 100/7 then 50/5 → done pulses 34 cycles apart with (14,2) then (10,0); in_ready low throughout CALC.
- Assert rst at cycle 10 of an op → no done; outputs 0 next cycle; in_ready high the cycle after rst falls; a subsequent 81/9 is correct. Sweep WIDTH=8 with random operands against a reference model.
